// File: rtl/wb_arbiter_2to1.sv
// Two-master Wishbone classic arbiter: round-robin per bus cycle, grant held while the winner's cycle is high.
// A stall watchdog raises a one-cycle err to the granted master when the slave stops acking.
module wb_arbiter_2to1 #(
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  input  logic                  m0_we_i,
  input  logic                  m0_cycle_i,
  input  logic                  m0_strobe_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  input  logic                  m1_we_i,
  input  logic                  m1_cycle_i,
  input  logic                  m1_strobe_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  output logic                  s_we_o,
  output logic                  s_cycle_o,
  output logic                  s_strobe_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack_i,
  output logic [1:0]            grant_o
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state, state_nxt;
  logic          last_grant, last_grant_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          sel_strobe, stall, timeout;

  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      count      <= count_nxt;
    end
  end

  // Tie in IDLE goes to the master that did not win last time.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (m0_cycle_i && (!m1_cycle_i || last_grant)) begin
          state_nxt      = GNT0;
          last_grant_nxt = 1'b0;
        end else if (m1_cycle_i) begin
          state_nxt      = GNT1;
          last_grant_nxt = 1'b1;
        end
      end
      GNT0:    if (!m0_cycle_i) state_nxt = IDLE;
      GNT1:    if (!m1_cycle_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_strobe = 1'b0;
    if (state == GNT0) sel_strobe = m0_strobe_i;
    if (state == GNT1) sel_strobe = m1_strobe_i;
    stall   = sel_strobe && !s_ack_i;
    timeout = (TIMEOUT_CYCLES > 0) && stall && (count == LIMIT);
    if ((TIMEOUT_CYCLES == 0) || !stall || timeout || (state_nxt == IDLE))
      count_nxt = '0;
    else
      count_nxt = count + CW'(1);
  end

  always_comb begin
    s_addr_o   = '0;
    s_data_o   = '0;
    s_we_o     = 1'b0;
    s_cycle_o  = 1'b0;
    s_strobe_o = 1'b0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    grant_o    = 2'b00;
    case (state)
      GNT0: begin
        s_addr_o   = m0_addr_i;
        s_data_o   = m0_data_i;
        s_we_o     = m0_we_i;
        s_cycle_o  = m0_cycle_i;
        s_strobe_o = m0_strobe_i;
        m0_ack_o   = s_ack_i && m0_strobe_i;
        m0_err_o   = timeout;
        grant_o    = 2'b01;
      end
      GNT1: begin
        s_addr_o   = m1_addr_i;
        s_data_o   = m1_data_i;
        s_we_o     = m1_we_i;
        s_cycle_o  = m1_cycle_i;
        s_strobe_o = m1_strobe_i;
        m1_ack_o   = s_ack_i && m1_strobe_i;
        m1_err_o   = timeout;
        grant_o    = 2'b10;
      end
      default: ;
    endcase
  end

  assign m_data_o = s_data_i;

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Bench for wb_arbiter_2to1: two scripted masters against a one-wait-state RAM model with ack gating.
module tb_wb_arbiter_2to1;
  localparam int AW = 20;
  localparam int DW = 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] cyc = '0, stb = '0, we = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdat0 = '0, wdat1 = '0;
  logic m0_ack, m0_err, m1_ack, m1_err;
  logic [DW-1:0] m_data, s_wdat, s_rdata;
  logic [AW-1:0] s_addr;
  logic s_we, s_cyc, s_stb, s_ack;
  logic [1:0] grant;
  logic ack_en = 1'b1;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp0[$], exp1[$];
  int ack_log[$];
  logic [1:0] gtrace[$];
  int cyc_n = 0;
  int nvec = 0, nfail = 0;

  always #5 clk = ~clk;

  wb_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clock_i(clk), .wb_reset_i(rst),
    .m0_addr_i(addr0), .m0_data_i(wdat0), .m0_we_i(we[0]), .m0_cycle_i(cyc[0]),
    .m0_strobe_i(stb[0]), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_addr_i(addr1), .m1_data_i(wdat1), .m1_we_i(we[1]), .m1_cycle_i(cyc[1]),
    .m1_strobe_i(stb[1]), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m_data_o(m_data), .s_addr_o(s_addr), .s_data_o(s_wdat), .s_we_o(s_we),
    .s_cycle_o(s_cyc), .s_strobe_o(s_stb), .s_data_i(s_rdata), .s_ack_i(s_ack),
    .grant_o(grant)
  );

  // RAM model: registered ack one cycle after strobe; ack_en=0 makes it a never-ack stub.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack   <= 1'b0;
      s_rdata <= '0;
    end else begin
      s_ack <= s_cyc & s_stb & ~s_ack & ack_en;
      if (s_cyc && s_stb && !s_ack) begin
        if (s_we) mem[s_addr[3:0]] <= s_wdat;
        s_rdata <= mem[s_addr[3:0]];
      end
    end
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (m0_ack) ack_log.push_back(0);
    if (m1_ack) ack_log.push_back(1);
    gtrace.push_back(grant);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, required finish");
    $fatal(1);
  end

  task automatic do_reset;
    cyc = '0; stb = '0; we = '0; ack_en = 1'b1;
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    ack_log.delete(); gtrace.delete(); exp0.delete(); exp1.delete();
  endtask

  // One classic cycle; reads push the expected word when issued and pop it on ack.
  task automatic txn(input int m, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input bit hold);
    bit got;
    logic [DW-1:0] expd;
    logic [1:0] gexp;
    @(posedge clk); #1;
    if (m == 0) begin addr0 = a; wdat0 = d; end
    else begin addr1 = a; wdat1 = d; end
    we[m] = w; cyc[m] = 1'b1; stb[m] = 1'b1;
    if (w) ref_mem[a[3:0]] = d;
    else if (m == 0) exp0.push_back(ref_mem[a[3:0]]);
    else exp1.push_back(ref_mem[a[3:0]]);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack : m1_ack) got = 1'b1;
    end
    nvec++;
    if (!got) begin
      $display("FAIL txn_ack m%0d addr %0h: no ack within 60 cycles", m, a);
      nfail++;
    end else begin
      gexp = (m == 0) ? 2'b01 : 2'b10;
      nvec++;
      if (grant !== gexp) begin
        $display("FAIL txn_grant m%0d: grant %b, required %b", m, grant, gexp);
        nfail++;
      end
      if (!w) begin
        expd = (m == 0) ? exp0.pop_front() : exp1.pop_front();
        nvec++;
        if (m_data !== expd) begin
          $display("FAIL read_data m%0d addr %0h: got %h, required %h", m, a, m_data, expd);
          nfail++;
        end
      end
    end
    @(posedge clk); #1;
    stb[m] = 1'b0;
    if (!hold) begin
      cyc[m] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    nvec += 4;
    if (grant !== 2'b00) begin $display("FAIL reset_grant: %b, required 00", grant); nfail++; end
    if ({s_cyc, s_stb, s_we} !== 3'b000) begin
      $display("FAIL reset_ctrl: cyc/stb/we %b, required 000", {s_cyc, s_stb, s_we}); nfail++;
    end
    if (s_addr !== '0 || s_wdat !== '0) begin
      $display("FAIL reset_bus: addr %h data %h, required 0", s_addr, s_wdat); nfail++;
    end
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin
      $display("FAIL reset_resp: ack/err %b, required 0000", {m0_ack, m0_err, m1_ack, m1_err}); nfail++;
    end
  endtask

  task automatic test_single;
    int ones;
    do_reset();
    txn(0, 1'b1, 20'h0, 8'h55, 1'b0);
    @(negedge clk);
    nvec++;
    if (grant !== 2'b00) begin $display("FAIL single_grant_after: %b, required 00", grant); nfail++; end
    txn(0, 1'b0, 20'h0, 8'h00, 1'b0);
    ones = 0;
    foreach (ack_log[i]) if (ack_log[i] != 0) ones++;
    nvec++;
    if (ack_log.size() != 2 || ones != 0) begin
      $display("FAIL single_acks: %0d acks with %0d from m1, required 2 with 0", ack_log.size(), ones);
      nfail++;
    end
  endtask

  task automatic test_simultaneous;
    int last01, first10;
    do_reset();
    fork
      txn(0, 1'b1, 20'h1, 8'hA5, 1'b0);
      txn(1, 1'b1, 20'h2, 8'h5A, 1'b0);
    join
    nvec++;
    if (ack_log.size() != 2 || ack_log[0] != 0 || ack_log[1] != 1) begin
      $display("FAIL simul_order: %0d acks, first m%0d, required m0 then m1", ack_log.size(),
               (ack_log.size() > 0) ? ack_log[0] : -1);
      nfail++;
    end
    last01 = -1; first10 = -1;
    foreach (gtrace[i]) begin
      if (gtrace[i] == 2'b01 && first10 < 0) last01 = i;
      if (gtrace[i] == 2'b10 && first10 < 0) first10 = i;
    end
    nvec++;
    if (last01 < 0 || first10 - last01 - 1 != 1) begin
      $display("FAIL simul_idle_gap: %0d idle cycles between grants, required 1", first10 - last01 - 1);
      nfail++;
    end
    txn(0, 1'b0, 20'h1, 8'h00, 1'b0);
    txn(1, 1'b0, 20'h2, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back;
    do_reset();
    fork
      for (int i = 0; i < 4; i++) txn(0, 1'b1, AW'(8 + i), DW'(8'h80 + i), 1'b0);
      for (int j = 0; j < 4; j++) txn(1, 1'b1, AW'(12 + j), DW'(8'hC0 + j), 1'b0);
    join
    nvec++;
    if (ack_log.size() != 8) begin
      $display("FAIL b2b_count: %0d acks, required 8", ack_log.size()); nfail++;
    end
    for (int k = 0; k < ack_log.size() && k < 8; k++) begin
      nvec++;
      if (ack_log[k] != (k % 2)) begin
        $display("FAIL b2b_order[%0d]: m%0d served, required m%0d", k, ack_log[k], k % 2); nfail++;
      end
    end
  endtask

  task automatic test_hold;
    int drop_n, g1_n, first1;
    bit seen0;
    do_reset();
    drop_n = -1; g1_n = -1; seen0 = 1'b0;
    fork
      begin
        txn(0, 1'b1, 20'h4, 8'h11, 1'b1);
        txn(0, 1'b1, 20'h5, 8'h22, 1'b1);
        txn(0, 1'b1, 20'h6, 8'h33, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        txn(1, 1'b1, 20'h7, 8'h77, 1'b0);
      end
      for (int i = 0; i < 100 && g1_n < 0; i++) begin
        @(negedge clk);
        if (grant == 2'b01) seen0 = 1'b1;
        if (seen0 && !cyc[0] && drop_n < 0) drop_n = cyc_n;
        if (grant == 2'b10 && g1_n < 0) g1_n = cyc_n;
      end
    join
    nvec++;
    if (drop_n < 0 || g1_n - drop_n != 2) begin
      $display("FAIL hold_regrant: m1 granted %0d cycles after drop, required 2", g1_n - drop_n);
      nfail++;
    end
    first1 = -1;
    foreach (ack_log[i]) if (ack_log[i] == 1 && first1 < 0) first1 = i;
    nvec++;
    if (first1 != 3) begin
      $display("FAIL hold_order: first m1 ack at position %0d, required 3", first1); nfail++;
    end
    txn(0, 1'b0, 20'h4, 8'h00, 1'b0);
    txn(0, 1'b0, 20'h5, 8'h00, 1'b0);
    txn(0, 1'b0, 20'h6, 8'h00, 1'b0);
  endtask

  task automatic test_timeout;
    int rise, err_at, acks, other_err;
    do_reset();
    ack_en = 1'b0;
    @(posedge clk); #1;
    addr1 = 20'h3; we[1] = 1'b0; cyc[1] = 1'b1; stb[1] = 1'b1;
    rise = -1; err_at = -1; acks = 0; other_err = 0;
    for (int i = 0; i < 30 && err_at < 0; i++) begin
      @(negedge clk);
      if (s_stb && rise < 0) rise = i;
      if (m1_ack) acks++;
      if (m0_err) other_err++;
      if (m1_err) err_at = i;
    end
    nvec += 2;
    if (rise < 0 || err_at < 0 || err_at - rise != TO - 1) begin
      $display("FAIL timeout_delay: err in stalled cycle %0d, required cycle %0d", err_at - rise + 1, TO);
      nfail++;
    end
    if (acks != 0 || other_err != 0) begin
      $display("FAIL timeout_side: %0d acks, %0d m0 errs, required 0 and 0", acks, other_err);
      nfail++;
    end
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    nvec++;
    if (m1_err !== 1'b0) begin $display("FAIL timeout_pulse: err %b after drop, required 0", m1_err); nfail++; end
    @(negedge clk);
    nvec++;
    if (grant !== 2'b00) begin $display("FAIL timeout_idle: grant %b, required 00", grant); nfail++; end
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid;
    bit granted;
    do_reset();
    ack_en = 1'b0;
    @(posedge clk); #1;
    addr0 = 20'h9; we[0] = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1;
    granted = 1'b0;
    for (int i = 0; i < 5 && !granted; i++) begin
      @(negedge clk);
      if (grant == 2'b01) granted = 1'b1;
    end
    nvec++;
    if (!granted) begin $display("FAIL rmid_grant: grant %b, required 01", grant); nfail++; end
    #1 rst = 1'b1;
    #1;
    nvec += 2;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin
      $display("FAIL rmid_async: cyc/stb %b%b during reset, required 00", s_cyc, s_stb); nfail++;
    end
    if (grant !== 2'b00) begin $display("FAIL rmid_grant_rst: %b, required 00", grant); nfail++; end
    #1 rst = 1'b0;
    addr1 = 20'hA; we[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1; ack_en = 1'b1;
    @(negedge clk);
    nvec++;
    if (grant !== 2'b01) begin $display("FAIL rmid_tie: grant %b, required 01", grant); nfail++; end
    @(posedge clk); #1;
    cyc = '0; stb = '0; we = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_hold();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
